// File: rtl/tinycore_pkg.sv
// Shared definitions for the tinycore accumulator machine: opcode and
// control-state enumerations plus small opcode classification helpers.
package tinycore_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDA   = 4'h1,
        OP_STA   = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_JMP   = 4'h8,
        OP_JZ    = 4'h9,
        OP_JC    = 4'hA,
        OP_LDI   = 4'hB,
        OP_RSV_C = 4'hC,
        OP_RSV_D = 4'hD,
        OP_RSV_E = 4'hE,
        OP_HLT   = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_F0   = 3'd0,
        ST_F1   = 3'd1,
        ST_O0   = 3'd2,
        ST_O1   = 3'd3,
        ST_M0   = 3'd4,
        ST_M1   = 3'd5,
        ST_HALT = 3'd6
    } state_e;

    // Reserved codes behave exactly like NOP.
    function automatic logic is_nop(input opcode_e op);
        return (op == OP_NOP) || (op == OP_RSV_C) || (op == OP_RSV_D) || (op == OP_RSV_E);
    endfunction

    // Instructions that finish once the operand word has been read.
    function automatic logic ends_in_o1(input opcode_e op);
        return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/tinycore_alu.sv
// Combinational ALU: computes the new accumulator value and flags for
// LDA and the arithmetic/logic opcodes from A and the memory operand M.
module tinycore_alu
    import tinycore_pkg::*;
#(
    parameter int DATA_SZ = 8
) (
    input  logic [3:0]         op,
    input  logic [DATA_SZ-1:0] a,
    input  logic [DATA_SZ-1:0] m,
    output logic [DATA_SZ-1:0] result,
    output logic               carry,
    output logic               zero
);

    logic [DATA_SZ:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, m};
        result = m;
        carry  = 1'b0;
        case (opcode_e'(op))
            OP_ADD: begin
                result = sum[DATA_SZ-1:0];
                carry  = sum[DATA_SZ];
            end
            OP_SUB: begin
                result = a - m;
                carry  = (a < m);
            end
            OP_AND:  result = a & m;
            OP_OR:   result = a | m;
            OP_XOR:  result = a ^ m;
            default: result = m;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/tinycore_acc.sv
// Multi-cycle accumulator core talking to a synchronous memory: fetch,
// operand read and memory access each take two cycles (address, data).
module tinycore_acc
    import tinycore_pkg::*;
#(
    parameter int                 ADDR_SZ   = 8,
    parameter int                 DATA_SZ   = 8,
    parameter logic [ADDR_SZ-1:0] RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_SZ-1:0] data_i,
    output logic [DATA_SZ-1:0] data_o,
    output logic [ADDR_SZ-1:0] addr,
    output logic               we,
    output logic               halt
);

    state_e             state_q, state_d;
    logic [ADDR_SZ-1:0] pc_q, pc_d;
    opcode_e            ir_q, ir_d;
    logic [ADDR_SZ-1:0] opr_q, opr_d;
    logic [DATA_SZ-1:0] a_q, a_d;
    logic               z_q, z_d;
    logic               c_q, c_d;

    opcode_e            op_in;
    logic [ADDR_SZ-1:0] operand;
    logic [DATA_SZ-1:0] alu_result;
    logic               alu_carry;
    logic               alu_zero;

    assign op_in   = opcode_e'(data_i[3:0]);
    assign operand = data_i[ADDR_SZ-1:0];

    tinycore_alu #(
        .DATA_SZ(DATA_SZ)
    ) u_alu (
        .op     (ir_q),
        .a      (a_q),
        .m      (data_i),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_F0;
            pc_q    <= RESET_VEC;
            ir_q    <= OP_NOP;
            opr_q   <= '0;
            a_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
            a_q     <= a_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_F0: state_d = ST_F1;
            ST_F1: begin
                if (is_nop(op_in))         state_d = ST_F0;
                else if (op_in == OP_HLT)  state_d = ST_HALT;
                else                       state_d = ST_O0;
            end
            ST_O0: state_d = ST_O1;
            ST_O1: state_d = ends_in_o1(ir_q) ? ST_F0 : ST_M0;
            ST_M0: state_d = (ir_q == OP_STA) ? ST_F0 : ST_M1;
            ST_M1: state_d = ST_F0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_F0;
        endcase
    end

    // Register updates happen only on the cycle whose data_i carries the word.
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        opr_d = opr_q;
        a_d   = a_q;
        z_d   = z_q;
        c_d   = c_q;
        case (state_q)
            ST_F1: begin
                ir_d = op_in;
                pc_d = pc_q + ADDR_SZ'(1);
            end
            ST_O1: begin
                opr_d = operand;
                pc_d  = pc_q + ADDR_SZ'(1);
                case (ir_q)
                    OP_JMP: pc_d = operand;
                    OP_JZ:  if (z_q) pc_d = operand;
                    OP_JC:  if (c_q) pc_d = operand;
                    OP_LDI: begin
                        a_d = data_i;
                        z_d = (data_i == '0);
                    end
                    default: ;
                endcase
            end
            ST_M1: begin
                a_d = alu_result;
                z_d = alu_zero;
                if (ir_q != OP_LDA) c_d = alu_carry;
            end
            default: ;
        endcase
    end

    always_comb begin
        addr   = ((state_q == ST_M0) || (state_q == ST_M1)) ? opr_q : pc_q;
        we     = (state_q == ST_M0) && (ir_q == OP_STA);
        halt   = (state_q == ST_HALT);
        data_o = a_q;
    end

endmodule

// File: tb/tb_tinycore_acc.sv
// Self-checking bench for tinycore_acc: directed program table, hand-written
// reset/halt sequences and random programs against an instruction-level model.
module tb_tinycore_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic [7:0] addr;
    logic       we;
    logic       halt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    tinycore_acc #(
        .ADDR_SZ   (8),
        .DATA_SZ   (8),
        .RESET_VEC (8'h00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .data_o (data_o),
        .addr   (addr),
        .we     (we),
        .halt   (halt)
    );

    // Synchronous memory: read data appears the cycle after addr.
    always @(posedge clk) begin
        if (we) mem[addr] <= data_o;
        data_i <= mem[addr];
    end

    typedef struct {
        string         name;
        logic [0:7][7:0] prog;
        logic [7:0]    m20;
        int            cyc;
        logic [7:0]    e_addr;
        logic [7:0]    e_a;
        logic          e_halt;
        logic [7:0]    e_m21;
    } vec_t;

    typedef struct {
        logic       chk_addr;
        logic [7:0] addr;
        logic       we;
        logic       halt;
        logic [7:0] data;
    } cyc_t;

    vec_t vecs [13];
    cyc_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rst_on();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Leaves the caller #1 after the negedge where rst fell: cycle 0 (first F0).
    task automatic rst_off();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic push(input logic ca, input logic [7:0] ad, input logic w,
                        input logic h, input logic [7:0] d);
        cyc_t e;
        e.chk_addr = ca;
        e.addr     = ad;
        e.we       = w;
        e.halt     = h;
        e.data     = d;
        exp_q.push_back(e);
    endtask

    // Instruction-level interpreter; each instruction expands into its
    // cycle count, with defined addresses on F0/O0/M0 and A changing only
    // once the instruction completes.
    task automatic build_trace();
        logic [7:0] mm [0:255];
        logic [7:0] pc, a, opnd, m;
        logic       z, c;
        logic [3:0] op;
        logic [8:0] s;
        for (int i = 0; i < 256; i++) mm[i] = mem[i];
        pc = 8'h00; a = 8'h00; z = 1'b0; c = 1'b0;
        exp_q.delete();
        for (int n = 0; n < 40; n++) begin
            op = mm[pc][3:0];
            push(1'b1, pc, 1'b0, 1'b0, a);
            push(1'b0, 8'h00, 1'b0, 1'b0, a);
            if (op == 4'hF) begin
                pc = pc + 8'd1;
                for (int k = 0; k < 4; k++) push(1'b1, pc, 1'b0, 1'b1, a);
                break;
            end
            if (op == 4'h0 || op >= 4'hC) begin
                pc = pc + 8'd1;
                continue;
            end
            opnd = mm[pc + 8'd1];
            push(1'b1, pc + 8'd1, 1'b0, 1'b0, a);
            push(1'b0, 8'h00, 1'b0, 1'b0, a);
            pc = pc + 8'd2;
            case (op)
                4'h8: pc = opnd;
                4'h9: if (z) pc = opnd;
                4'hA: if (c) pc = opnd;
                4'hB: begin a = opnd; z = (a == 8'h00); end
                4'h2: begin
                    push(1'b1, opnd, 1'b1, 1'b0, a);
                    mm[opnd] = a;
                end
                default: begin
                    m = mm[opnd];
                    push(1'b1, opnd, 1'b0, 1'b0, a);
                    push(1'b0, 8'h00, 1'b0, 1'b0, a);
                    case (op)
                        4'h1: a = m;
                        4'h3: begin s = {1'b0, a} + {1'b0, m}; c = s[8]; a = s[7:0]; end
                        4'h4: begin c = (a < m); a = a - m; end
                        4'h5: begin a = a & m; c = 1'b0; end
                        4'h6: begin a = a | m; c = 1'b0; end
                        default: begin a = a ^ m; c = 1'b0; end
                    endcase
                    z = (a == 8'h00);
                end
            endcase
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        int   we_cnt;
        logic ok;
        cyc_t e;

        vecs[0]  = '{"add_carry",  {8'h0B,8'h05,8'h03,8'h20,8'h02,8'h21,8'h0F,8'h00}, 8'hFC, 17, 8'h07, 8'h01, 1'b1, 8'h01};
        vecs[1]  = '{"sub_borrow_jc", {8'h0B,8'h03,8'h04,8'h20,8'h0A,8'h40,8'h00,8'h00}, 8'h04, 14, 8'h40, 8'hFF, 1'b0, 8'h00};
        vecs[2]  = '{"jz_taken",   {8'h0B,8'h00,8'h09,8'h50,8'h00,8'h00,8'h00,8'h00}, 8'h00, 8, 8'h50, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{"jz_fall",    {8'h0B,8'h01,8'h09,8'h50,8'h00,8'h00,8'h00,8'h00}, 8'h00, 8, 8'h04, 8'h01, 1'b0, 8'h00};
        vecs[4]  = '{"jc_fall",    {8'h0B,8'h05,8'h03,8'h20,8'h0A,8'h40,8'h00,8'h00}, 8'h01, 14, 8'h06, 8'h06, 1'b0, 8'h00};
        vecs[5]  = '{"and_clr_c",  {8'h0B,8'h03,8'h04,8'h20,8'h05,8'h20,8'h0A,8'h40}, 8'h04, 20, 8'h08, 8'h04, 1'b0, 8'h00};
        vecs[6]  = '{"lda_keep_c", {8'h0B,8'h03,8'h04,8'h20,8'h01,8'h20,8'h0A,8'h40}, 8'h04, 20, 8'h40, 8'h04, 1'b0, 8'h00};
        vecs[7]  = '{"xor_zero",   {8'h0B,8'h0F,8'h07,8'h20,8'h09,8'h50,8'h00,8'h00}, 8'h0F, 14, 8'h50, 8'h00, 1'b0, 8'h00};
        vecs[8]  = '{"hlt_first",  {8'h0F,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'h00, 2, 8'h01, 8'h00, 1'b1, 8'h00};
        vecs[9]  = '{"nop_ldi",    {8'h00,8'h0B,8'hAA,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'h00, 6, 8'h03, 8'hAA, 1'b0, 8'h00};
        vecs[10] = '{"pc_wrap",    {8'h08,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 8'h00, 6, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[11] = '{"sta_keep_z", {8'h0B,8'h00,8'h06,8'h20,8'h02,8'h21,8'h09,8'h50}, 8'h00, 19, 8'h50, 8'h00, 1'b0, 8'h00};
        vecs[12] = '{"sub_equal",  {8'h0B,8'h04,8'h04,8'h20,8'h0A,8'h40,8'h00,8'h00}, 8'h04, 14, 8'h06, 8'h00, 1'b0, 8'h00};

        // Reset values and first fetch address.
        clear_mem();
        mem[0] = 8'h0B; mem[1] = 8'h77; mem[2] = 8'h02; mem[3] = 8'h21;
        repeat (2) @(negedge clk);
        #1;
        check("rst_addr", addr, 8'h00);
        check("rst_we", we, 1'b0);
        check("rst_halt", halt, 1'b0);
        check("rst_data", data_o, 8'h00);
        rst_off();
        check("first_fetch_addr", addr, 8'h00);

        // Reset rising during the store's memory cycle.
        repeat (8) next_cycle();
        check("sta_m0_we", we, 1'b1);
        check("sta_m0_addr", addr, 8'h21);
        check("sta_m0_data", data_o, 8'h77);
        rst = 1'b1;
        #1;
        check("midstore_we", we, 1'b0);
        check("midstore_addr", addr, 8'h00);
        check("midstore_data", data_o, 8'h00);
        @(negedge clk);
        check("midstore_mem", mem[8'h21], 8'h00);
        rst = 1'b0;
        #1;
        check("restart_addr", addr, 8'h00);
        repeat (2) next_cycle();
        check("restart_o0_addr", addr, 8'h01);

        // Directed program table.
        for (int v = 0; v < 13; v++) begin
            rst_on();
            clear_mem();
            for (int k = 0; k < 8; k++) mem[k] = vecs[v].prog[k];
            mem[8'h20] = vecs[v].m20;
            rst_off();
            repeat (vecs[v].cyc) next_cycle();
            check({vecs[v].name, "_addr"}, addr, vecs[v].e_addr);
            check({vecs[v].name, "_a"}, data_o, vecs[v].e_a);
            check({vecs[v].name, "_halt"}, halt, vecs[v].e_halt);
            check({vecs[v].name, "_m21"}, mem[8'h21], vecs[v].e_m21);
        end

        // Halt timing, single store strobe, halt persistence and exit by reset.
        rst_on();
        clear_mem();
        for (int k = 0; k < 8; k++) mem[k] = vecs[0].prog[k];
        mem[8'h20] = 8'hFC;
        rst_off();
        seen = -1;
        we_cnt = 0;
        for (int i = 0; i < 100 && seen < 0; i++) begin
            if (halt) seen = i;
            else begin
                if (we) we_cnt++;
                next_cycle();
            end
        end
        check("halt_latency", seen, 17);
        check("store_strobes", we_cnt, 1);
        repeat (10) next_cycle();
        check("halt_hold", halt, 1'b1);
        check("halt_we", we, 1'b0);
        check("halt_addr", addr, 8'h07);
        rst = 1'b1;
        #1;
        check("halt_rst_exit", halt, 1'b0);

        // Random programs against the instruction-level model.
        for (int r = 0; r < 10; r++) begin
            rst_on();
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom_range(0, 255));
                if (mem[i][3:0] == 4'hF && $urandom_range(0, 3) != 0) mem[i][3:0] = 4'h0;
            end
            build_trace();
            rst_off();
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i > 0) next_cycle();
                e = exp_q[i];
                ok = (we === e.we) && (halt === e.halt) && (data_o === e.data) &&
                     (!e.chk_addr || addr === e.addr);
                n_tests++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL rand%0d_cyc%0d: got addr=%h we=%b halt=%b data=%h expected addr=%h(chk %b) we=%b halt=%b data=%h",
                             r, i, addr, we, halt, data_o, e.addr, e.chk_addr, e.we, e.halt, e.data);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tinycore_acc.md
TINYCORE_ACC -- requirements
Module: tinycore_acc

Interface
REQ-001 SHALL have parameter ADDR_SZ, default 8, address width; PC wraps modulo 2^ADDR_SZ.
REQ-002 SHALL have parameter DATA_SZ, default 8, data/instruction word width; legal only when DATA_SZ >= ADDR_SZ and DATA_SZ >= 4.
REQ-003 SHALL have parameter RESET_VEC, default 0, ADDR_SZ-bit PC value after reset.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port data_i  input  DATA_SZ  read data from synchronous memory, valid the cycle after addr is presented.
REQ-007 SHALL have port data_o  output  DATA_SZ  write data, equal to accumulator A.
REQ-008 SHALL have port addr  output  ADDR_SZ  memory address, driven from registered state only.
REQ-009 SHALL have port we  output  1  memory write strobe, one cycle per store.
REQ-010 SHALL have port halt  output  1  high while the core is in HALT.

Function
REQ-011 SHALL be a multi-cycle accumulator core with registers PC, IR (4 bits), OPR (ADDR_SZ bits), A (DATA_SZ bits), Z and C flags.
REQ-012 SHALL decode the opcode from data_i[3:0] of the first instruction word; the second word, when present, supplies the operand (low ADDR_SZ bits as address, full word for LDI).
REQ-013 SHALL implement opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 JMP, 9 JZ, A JC, B LDI, F HLT; codes C-E SHALL execute as NOP.
REQ-014 SHALL run states F0 (addr=PC) -> F1 (IR<=data_i, PC<=PC+1); from F1: NOP -> F0, HLT -> HALT, else O0.
REQ-015 SHALL run O0 (addr=PC) -> O1 (OPR<=data_i, PC<=PC+1); in O1: JMP loads PC<=operand; JZ/JC load it only if Z/C set; LDI A<=data_i; all four -> F0; others -> M0.
REQ-016 SHALL run M0 (addr=OPR); STA asserts we with data_o=A and -> F0; LDA/ALU ops -> M1.
REQ-017 SHALL in M1 compute A<=f(A,data_i), update flags, -> F0.
REQ-018 SHALL produce instruction latencies: NOP/HLT 2 cycles, JMP/JZ/JC/LDI 4, STA 5, LDA/ALU 6.
REQ-019 SHALL compute ADD as {C,A} <= A + M (DATA_SZ+1 bits); SUB as A <= A - M with C=1 iff A < M (borrow).
REQ-020 SHALL clear C on AND/OR/XOR; LDA and LDI SHALL leave C unchanged.
REQ-021 SHALL set Z = (A result == 0) on LDA, LDI and all ALU ops; STA and jumps SHALL leave flags unchanged.
REQ-022 SHALL hold HALT indefinitely, with we=0 and addr=PC of the instruction following HLT; only reset exits HALT.
REQ-023 SHALL increment PC from 2^ADDR_SZ-1 to 0 with no flag effect.

Reset
REQ-024 SHALL, while rst is high, force state=F0, PC=RESET_VEC, A=0, IR=0, OPR=0, Z=0, C=0, we=0, halt=0, data_o=0, addr=RESET_VEC, all asynchronously.
REQ-025 SHALL abandon any in-flight instruction on reset, including dropping we in the same cycle if rst rises during an STA M0.
REQ-026 SHALL begin fetching at RESET_VEC on the first rising clk edge after rst falls.

Structure
REQ-027 SHALL place the opcode enumeration and the state enumeration (F0, F1, O0, O1, M0, M1, HALT) in shared package tinycore_pkg.
REQ-028 SHALL instantiate one combinational sub-module, tinycore_alu (inputs op, A, M; outputs result, carry, zero).

Verification
REQ-029 SHALL cover reset: rst=1 -> addr=0x00, we=0, halt=0, data_o=0; after release, the first F0 drives addr 0x00.
REQ-030 SHALL cover add with carry: LDI 0x05; ADD [0x20]=0xFC; STA 0x21; HLT -> mem[0x21]=0x01, C=1, Z=0; halt rises 17 cycles after the first fetch.
REQ-031 SHALL cover borrow and JC: LDI 0x03; SUB [0x20]=0x04; JC 0x40 -> A=0xFF, C=1, next fetch addr=0x40.
REQ-032 SHALL cover JZ: LDI 0x00; JZ 0x50 -> fetch at 0x50; repeated with LDI 0x01 -> fetch falls through to the following address.
REQ-033 SHALL cover PC wrap: NOP at 0xFF -> next fetch addr=0x00.
REQ-034 SHALL cover reset mid-store: rst asserted during STA M0 -> we=0 in that cycle, memory unchanged, fetch restarts at 0x00.
